// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the waveform shaper:
//   state_t  - controller states (IDLE waits for a period boundary, RUN shapes)
//   mode_t   - waveform selection codes carried on mode / mode_active
//   sineEntry - elaboration-time helper that produces one quarter-wave table
//               entry, floor((2^(n-1) - 0.5) * sin(pi*(2k+1)/2^n)), using
//               integer fixed-point math so that no real arithmetic reaches
//               the netlist.
// ---------------------------------------------------------------------------
package wave_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    SAW  = 3'd0,
    RSAW = 3'd1,
    SQR  = 3'd2,
    TRI  = 3'd3,
    SIN  = 3'd4
  } mode_t;

  // pi scaled by 2^30; Q30 keeps x*x inside a signed 64-bit product.
  localparam longint PI_Q30       = 64'sd3373259426;
  localparam int     TAYLOR_TERMS = 10;

  // Taylor series for sin(x) in Q30, then scaled by (2^n - 1)/2, which is
  // the (H - 0.5) amplitude expressed without fractions. The argument never
  // exceeds pi/2, so ten terms are far below one LSB of error.
  function automatic int sineEntry(input int n, input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (PI_Q30 * longint'(2 * k + 1)) >>> n;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int j = 1; j <= TAYLOR_TERMS; j++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * j) * (2 * j + 1)));
      sum  = sum + term;
    end
    amp = (((longint'(1) << n) - 1) * sum) >>> 31;
    return int'(amp);
  endfunction

endpackage

// File: rtl/sine_rom.sv
// ---------------------------------------------------------------------------
// sine_rom
// Combinational quarter-wave sine table with 2^(N-2) entries of N-1 bits.
// The contents are fixed at elaboration; the parent mirrors and offsets the
// entries to build a full period.
// Ports:
//   i_addr [N-3:0] - table index k
//   o_data [N-2:0] - rom[k]
// ---------------------------------------------------------------------------
module sine_rom
  import wave_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-3:0] i_addr,
  output logic [N-2:0] o_data
);

  localparam int DEPTH = 2 ** (N - 2);

  logic [N-2:0] w_table [DEPTH];

  // Every entry is an elaboration-time constant, so this folds into a
  // plain lookup table.
  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    localparam int VALUE = sineEntry(N, k);
    assign w_table[k] = VALUE[N-2:0];
  end

  assign o_data = w_table[i_addr];

endmodule

// File: rtl/wave_shaper.sv
// ---------------------------------------------------------------------------
// wave_shaper
// Turns the phase count of an upstream up-counter into one of several
// periodic waveforms. A new mode/duty request only takes effect at a period
// boundary (the counter carry), so every emitted period is complete.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous reset, active low
//   cnt  [N-1:0]- phase count from the upstream counter
//   co          - upstream carry-out (cnt all ones and counting)
//   en          - sample strobe shared with the upstream counter
//   clr         - synchronous return to IDLE, overrides en/co
//   mode [2:0]  - requested waveform
//   duty [N-1:0]- requested square-wave threshold
//   wave [N-1:0]- registered unsigned sample
//   mode_active - waveform currently being generated
//   cycle_done  - one-clock pulse after each period boundary
// N must be at least 4 so the sine quadrant split leaves a table index.
// ---------------------------------------------------------------------------
module wave_shaper
  import wave_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cnt,
  input  logic         co,
  input  logic         en,
  input  logic         clr,
  input  logic [2:0]   mode,
  input  logic [N-1:0] duty,
  output logic [N-1:0] wave,
  output logic [2:0]   mode_active,
  output logic         cycle_done
);

  state_t       r_state;
  logic [2:0]   r_modeActive;
  logic [N-1:0] r_dutyActive;
  logic         r_phase;
  logic [N-1:0] r_wave;
  logic         r_cycleDone;

  logic [1:0]   w_quadrant;
  logic [N-3:0] w_romAddr;
  logic [N-2:0] w_romData;
  logic [N-1:0] w_sample;
  logic         w_boundary;

  assign w_boundary = en && co;

  // Odd quadrants read the table backwards; ~index equals M - index.
  assign w_quadrant = cnt[N-1:N-2];
  assign w_romAddr  = w_quadrant[0] ? ~cnt[N-3:0] : cnt[N-3:0];

  sine_rom #(
    .N(N)
  ) u_sine_rom (
    .i_addr(w_romAddr),
    .o_data(w_romData)
  );

  // Sample for the current count under the latched mode. For sine, the
  // upper half is H + rom = {1, rom} and the lower half is H - 1 - rom =
  // {0, ~rom}, so no adder is needed.
  always_comb begin
    w_sample = '0;
    case (r_modeActive)
      SAW:     w_sample = cnt;
      RSAW:    w_sample = ~cnt;
      SQR:     w_sample = (cnt < r_dutyActive) ? {N{1'b1}} : {N{1'b0}};
      TRI:     w_sample = r_phase ? ~cnt : cnt;
      SIN:     w_sample = w_quadrant[1] ? {1'b0, ~w_romData} : {1'b1, w_romData};
      default: w_sample = '0;
    endcase
  end

  // Controller. IDLE tracks the requested mode continuously and waits for a
  // carry; RUN samples on every strobe and only re-latches mode/duty and
  // flips the triangle direction on a carry, so the carry sample itself
  // still belongs to the old period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_modeActive <= '0;
      r_dutyActive <= '0;
      r_phase      <= 1'b0;
      r_wave       <= '0;
      r_cycleDone  <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_wave      <= '0;
      r_phase     <= 1'b0;
      r_cycleDone <= 1'b0;
      if (r_state == IDLE) begin
        r_modeActive <= mode;
        r_dutyActive <= duty;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_modeActive <= mode;
          r_dutyActive <= duty;
          r_wave       <= '0;
          r_phase      <= 1'b0;
          r_cycleDone  <= w_boundary;
          if (w_boundary) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            r_wave <= w_sample;
          end
          r_cycleDone <= w_boundary;
          if (w_boundary) begin
            r_modeActive <= mode;
            r_dutyActive <= duty;
            r_phase      <= ~r_phase;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wave        = r_wave;
  assign mode_active = r_modeActive;
  assign cycle_done  = r_cycleDone;

endmodule

// File: doc/wave_shaper.md
WAVE_SHAPER -- requirements
Module: wave_shaper

Interface
REQ-001 Parameter N, default 8, meaning phase-count and sample width in bits; N >= 4 SHALL hold.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 cnt  input  N  phase count from the upstream up-counter.
REQ-005 co  input  1  upstream carry-out; high when cnt is all-ones and the count is enabled.
REQ-006 en  input  1  sample strobe; same enable that advances the upstream counter.
REQ-007 clr  input  1  synchronous clear; returns the block to IDLE.
REQ-008 mode  input  3  requested waveform.
REQ-009 duty  input  N  requested square-wave threshold.
REQ-010 wave  output  N  registered waveform sample, unsigned.
REQ-011 mode_active  output  3  waveform currently being generated.
REQ-012 cycle_done  output  1  one-clk pulse marking a period boundary.

Function
REQ-013 States SHALL be IDLE and RUN; IDLE->RUN on any cycle with en=1 and co=1; RUN->IDLE only on clr or reset.
REQ-014 In IDLE, mode_active and duty_active SHALL load mode/duty every clk; wave SHALL be 0; phase SHALL be 0.
REQ-015 In RUN, mode_active/duty_active SHALL load only on cycles with en=1 and co=1; mode/duty changes at other times are ignored.
REQ-016 In RUN with en=1, wave SHALL load f(cnt, mode_active, duty_active, phase) at the next edge (latency 1 clk); with en=0, wave SHALL hold.
REQ-017 The sample taken on a co cycle SHALL use the old mode; the new mode applies from the following sample (cnt=0).
REQ-018 Mode 0 sawtooth: f=cnt.
REQ-019 Mode 1 reverse sawtooth: f=~cnt.
REQ-020 Mode 2 square: f=all-ones if cnt < duty_active, else 0; duty=0 gives constant 0; duty=all-ones gives 0 only at cnt=all-ones.
REQ-021 Mode 3 triangle: f=cnt when phase=0, ~cnt when phase=1; period 2*2^N samples; the peak and trough samples each repeat once.
REQ-022 Phase SHALL toggle on every en=1, co=1 cycle in RUN; the IDLE->RUN transition SHALL leave phase at 0.
REQ-023 Mode 4 sine: q=cnt[N-1:N-2], i=cnt[N-3:0], M=2^(N-2)-1, H=2^(N-1); q0: H+rom[i]; q1: H+rom[M-i]; q2: H-1-rom[i]; q3: H-1-rom[M-i].
REQ-024 rom[k]=floor((H-0.5)*sin(pi*(2k+1)/2^N)), k=0..M, N-1 bits wide; for N=8, rom[0]=1 and rom[63]=127.
REQ-025 Modes 5-7 are reserved: f=0; they are still latched into mode_active.
REQ-026 cycle_done SHALL be 1 for exactly the clk following each en=1, co=1 edge in RUN and at the IDLE->RUN transition; otherwise 0.
REQ-027 clr SHALL take priority over en/co: the next state is IDLE, wave=0, phase=0, cycle_done=0.
REQ-028 All arithmetic SHALL be unsigned at N bits; no saturation is needed because every f stays within 0..2^N-1.

Reset
REQ-029 While rst=0: state=IDLE, wave=0, mode_active=0, duty_active=0, phase=0, cycle_done=0, independent of clk.
REQ-030 Reset deassertion mid-period SHALL resume in IDLE and wait for the next co; no partial period is output.

Structure
REQ-031 Package wave_pkg SHALL hold the mode encodings (SAW=0, RSAW=1, SQR=2, TRI=3, SIN=4) and the IDLE/RUN state encoding.
REQ-032 Sub-module sine_rom (parameter N, combinational quarter-wave table per REQ-024) SHALL be the only child instance.
REQ-033 wave, mode_active, duty_active, phase, state and cycle_done SHALL all be flops; no combinational path from inputs to outputs.

Verification
REQ-034 Reset, free-running cnt 0..255, en=1, mode=0 -> wave=0 until the first co; then wave equals the previous cycle's cnt; cycle_done pulses once per 256 clks.
REQ-035 Mode 2, duty=64 -> wave=255 for cnt 0..63 and 0 for cnt 64..255; change duty to 192 mid-period -> takes effect only after the next co.
REQ-036 Mode 3 -> across 512 samples wave ramps 0..255 then 255..0; phase toggles at each co.
REQ-037 Mode 4, N=8 -> cnt=0 gives 129, cnt=63 gives 255, cnt=128 gives 126, cnt=191 gives 0.
REQ-038 Switch mode 0->1 at cnt=100 -> wave keeps sawtooth until the co sample (255), then shows 255 for cnt=0; mode_active changes at the same edge.
REQ-039 clr=1 with co=1 in RUN -> IDLE, wave=0, no cycle_done; rst pulse at cnt=50 -> all outputs 0 immediately, output restarts after the next co.
